dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Decides once per cycle which requester drives the memory's write enable, access type, address and write data.
- Rejects misaligned or illegal accesses before they reach the memory.
- Returns registered read data, a valid pulse and an error flag to the requester that was granted.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-ported data memory between two requesters. Port 0 is the
//   core load/store unit and port 1 is the DMA/debug loader. Each cycle one
//   requester is granted combinationally. Port 0 wins conflicts unless port 1
//   has been denied for STARVE_LIMIT consecutive cycles. Misaligned or illegal
//   accesses are granted but never reach the memory, and they report an error.
//   Read data, a valid pulse and an error flag return to the granted port on
//   the following cycle.
//
// Parameters
//   STARVE_LIMIT  denied cycles before port 1 gets a forced grant (1..15)
//   ADDR_W        byte address width
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   req/we/dtype/addr/wdata{0,1}   request fields per port
//   gnt{0,1}                       combinational grant
//   rvalid/rdata/err{0,1}          registered response per port
//   mem_we, data_type, mem_adress, wr_data   memory request side
//   data_out                       combinational memory read data
//
// Optional feature (macro DMEM_ARB_STATS_EN)
//   stat_gnt0, stat_gnt1, stat_conflict: 16-bit saturating event counters
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [2:0]        dtype0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [2:0]        dtype1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
  output logic              err1,
  output logic              mem_we,
  output logic [2:0]        data_type,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [31:0]       wr_data,
  input  logic [31:0]       data_out
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t state, state_next;
  logic [3:0] starve_cnt, starve_next;

  logic [2:0]        hold_type;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_wdata;

  logic ill0, ill1;

  // An access is illegal when its address is not aligned to the access size,
  // the type code is undefined, or it is a store of an unsigned load type.
  function automatic logic is_illegal(input logic we, input logic [2:0] dt,
                                      input logic [1:0] a);
    logic bad;
    case (dt)
      3'b000:         bad = (a != 2'b00);
      3'b001, 3'b011: bad = a[0];
      3'b010, 3'b100: bad = 1'b0;
      default:        bad = 1'b1;
    endcase
    if (we && (dt == 3'b011 || dt == 3'b100)) bad = 1'b1;
    return bad;
  endfunction

  assign ill0 = is_illegal(we0, dtype0, addr0[1:0]);
  assign ill1 = is_illegal(we1, dtype1, addr1[1:0]);

  // Grants are forced low while reset is asserted so that a reset pulse
  // between edges removes the in-flight access from the memory immediately.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_next  = IDLE;
    starve_next = starve_cnt;
    if (!rst) begin
      if (req0 && req1) begin
        if (starve_cnt == LIMIT) gnt1 = 1'b1;
        else                     gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    if (gnt0)      state_next = OWN0;
    else if (gnt1) state_next = OWN1;
    if (!req1 || gnt1)          starve_next = 4'd0;
    else if (starve_cnt != LIMIT) starve_next = starve_cnt + 4'd1;
  end

  // With no grant the memory sees the last granted fields, but never a write.
  always_comb begin
    mem_we     = 1'b0;
    data_type  = hold_type;
    mem_adress = hold_addr;
    wr_data    = hold_wdata;
    if (gnt0) begin
      mem_we     = we0 & ~ill0;
      data_type  = dtype0;
      mem_adress = addr0;
      wr_data    = wdata0;
    end else if (gnt1) begin
      mem_we     = we1 & ~ill1;
      data_type  = dtype1;
      mem_adress = addr1;
      wr_data    = wdata1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      hold_type  <= 3'd0;
      hold_addr  <= '0;
      hold_wdata <= 32'd0;
      rdata0     <= 32'd0;
      err0       <= 1'b0;
      rdata1     <= 32'd0;
      err1       <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (gnt0 || gnt1) begin
        hold_type  <= data_type;
        hold_addr  <= mem_adress;
        hold_wdata <= wr_data;
      end
      if (gnt0) begin
        rdata0 <= (ill0 || we0) ? 32'd0 : data_out;
        err0   <= ill0;
      end
      if (gnt1) begin
        rdata1 <= (ill1 || we1) ? 32'd0 : data_out;
        err1   <= ill1;
      end
    end
  end

  // The registered owner of the previous cycle is exactly the response route.
  assign rvalid0 = (state == OWN0);
  assign rvalid1 = (state == OWN1);

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_gnt0     <= 16'd0;
      stat_gnt1     <= 16'd0;
      stat_conflict <= 16'd0;
    end else begin
      if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (req0 && req1 && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [2:0] dtype0 = 0, dtype1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic gnt0, rvalid0, err0, gnt1, rvalid1, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_adress, wr_data, data_out;
  logic [2:0] data_type;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
  int m_sg0, m_sg1, m_sc;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int starve;
  logic eg0, eg1, erv0, erv1, eerr0, eerr1, e_we;
  logic [31:0] erd0, erd1, e_addr, e_wd, h_addr, h_wd;
  logic [2:0] e_type, h_type;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .dtype0(dtype0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .dtype1(dtype1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .data_type(data_type), .mem_adress(mem_adress),
    .wr_data(wr_data), .data_out(data_out)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Memory access types: sub-word loads extract and extend, stores merge.
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] dt,
                                           input logic [1:0] a);
    logic [31:0] s;
    s = w >> (int'(a) * 8);
    case (dt)
      3'd0: return w;
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd2: return {{24{s[7]}}, s[7:0]};
      3'd3: return {16'd0, s[15:0]};
      3'd4: return {24'd0, s[7:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [2:0] dt,
                                            input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    sh = int'(a) * 8;
    case (dt)
      3'd0: return wd;
      3'd1, 3'd3: m = 32'h0000FFFF << sh;
      3'd2, 3'd4: m = 32'h000000FF << sh;
      default: return w;
    endcase
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  always @(posedge clk)
    if (mem_we) mem[mem_adress[7:2]] <= store_val(mem[mem_adress[7:2]], data_type,
                                                  mem_adress[1:0], wr_data);

  always_comb data_out = load_val(mem[mem_adress[7:2]], data_type, mem_adress[1:0]);

  // Reference legality: size-aligned address, defined type, no unsigned store.
  function automatic bit bad(input logic we, input logic [2:0] dt, input logic [31:0] a);
    int size;
    if (dt > 3'd4) return 1'b1;
    size = (dt == 3'd0) ? 4 : ((dt == 3'd1 || dt == 3'd3) ? 2 : 1);
    if ((int'(a[7:0]) % size) != 0) return 1'b1;
    return we && (dt == 3'd3 || dt == 3'd4);
  endfunction

  task automatic model_reset();
    starve = 0;
    erv0 = 0; erv1 = 0; erd0 = 0; erd1 = 0; eerr0 = 0; eerr1 = 0;
    h_addr = 0; h_wd = 0; h_type = 0;
`ifdef DMEM_ARB_STATS_EN
    m_sg0 = 0; m_sg1 = 0; m_sc = 0;
`endif
  endtask

  task automatic model_predict();
    eg0 = 0; eg1 = 0;
    if (req0 && req1) begin
      if (starve == STARVE_LIMIT) eg1 = 1; else eg0 = 1;
    end else if (req0) eg0 = 1;
    else if (req1) eg1 = 1;
    e_we = 0; e_type = h_type; e_addr = h_addr; e_wd = h_wd;
    if (eg0) begin
      e_we = we0 && !bad(we0, dtype0, addr0);
      e_type = dtype0; e_addr = addr0; e_wd = wdata0;
    end else if (eg1) begin
      e_we = we1 && !bad(we1, dtype1, addr1);
      e_type = dtype1; e_addr = addr1; e_wd = wdata1;
    end
  endtask

  task automatic port_resp(input logic we, input logic [2:0] dt, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er);
    if (bad(we, dt, a)) begin
      rd = 0; er = 1;
    end else if (we) begin
      rd = 0; er = 0;
      ref_mem[a[7:2]] = store_val(ref_mem[a[7:2]], dt, a[1:0], wd);
    end else begin
      rd = load_val(ref_mem[a[7:2]], dt, a[1:0]); er = 0;
    end
  endtask

  task automatic model_commit();
`ifdef DMEM_ARB_STATS_EN
    if (eg0 && m_sg0 < 65535) m_sg0++;
    if (eg1 && m_sg1 < 65535) m_sg1++;
    if (req0 && req1 && m_sc < 65535) m_sc++;
`endif
    if (req1 && !eg1) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
    else starve = 0;
    erv0 = eg0; erv1 = eg1;
    if (eg0) port_resp(we0, dtype0, addr0, wdata0, erd0, eerr0);
    if (eg1) port_resp(we1, dtype1, addr1, wdata1, erd1, eerr1);
    if (eg0 || eg1) begin h_type = e_type; h_addr = e_addr; h_wd = e_wd; end
  endtask

  task automatic sample();
    @(negedge clk);
    model_predict();
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic new_req(output logic we, output logic [2:0] dt,
                         output logic [31:0] a, output logic [31:0] wd);
    dt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    we = 1'($urandom_range(0, 1));
    if (we && (dt == 3'd3 || dt == 3'd4) && $urandom_range(0, 4) != 0) dt = dt - 3'd2;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) begin
      if (dt == 3'd0) a[1:0] = 2'b00;
      else if (dt == 3'd1 || dt == 3'd3) a[0] = 1'b0;
    end
    wd = $urandom;
  endtask

  task automatic test_reset();
    req0 = 1; we0 = 1; dtype0 = 3'd2; addr0 = 32'h44; wdata0 = 32'hA5A5A5A5;
    req1 = 1; we1 = 1; dtype1 = 3'd1; addr1 = 32'h22; wdata1 = 32'h5A5A5A5A;
    #1 rst = 1;
    @(negedge clk);
    checks += 12;
    if (gnt0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt0: got %b expected 0", gnt0); end
    if (gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt1: got %b expected 0", gnt1); end
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    if (data_type !== 3'd0) begin errors++; $display("[TB] FAIL reset_data_type: got %h expected 0", data_type); end
    if (mem_adress !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_adress: got %h expected 0", mem_adress); end
    if (wr_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    if (rvalid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid0: got %b expected 0", rvalid0); end
    if (rvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid1: got %b expected 0", rvalid1); end
    if (rdata0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata0: got %h expected 0", rdata0); end
    if (rdata1 !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata1: got %h expected 0", rdata1); end
    if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err0: got %b expected 0", err0); end
    if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err1: got %b expected 0", err1); end
`ifdef DMEM_ARB_STATS_EN
    checks++;
    if (stat_gnt0 !== 0 || stat_gnt1 !== 0 || stat_conflict !== 0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got %h %h %h expected 0 0 0", stat_gnt0, stat_gnt1, stat_conflict);
    end
`endif
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1; we0 = 1; dtype0 = 3'd0; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    sample();
    checks += 4;
    if (gnt0 !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt0: got %b expected 1", gnt0); end
    if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_mem_we: got %b expected 1", mem_we); end
    if (mem_adress !== 32'h10) begin errors++; $display("[TB] FAIL wr_mem_adress: got %h expected 10", mem_adress); end
    if (wr_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_wr_data: got %h expected deadbeef", wr_data); end
    next_cycle();
    we0 = 0;
    sample();
    checks += 3;
    if (rvalid0 !== 1'b1) begin errors++; $display("[TB] FAIL wr_rvalid0: got %b expected 1", rvalid0); end
    if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL wr_err0: got %b expected 0", err0); end
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_mem_we: got %b expected 0", mem_we); end
    next_cycle();
    req0 = 0;
    sample();
    checks += 3;
    if (rvalid0 !== 1'b1) begin errors++; $display("[TB] FAIL rd_rvalid0: got %b expected 1", rvalid0); end
    if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata0: got %h expected deadbeef", rdata0); end
    if (gnt0 !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle_gnt0: got %b expected 0", gnt0); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic p1, prev0, prev1;
    do_reset();
    req0 = 1; we0 = 0; dtype0 = 3'd0; addr0 = 32'h20;
    req1 = 1; we1 = 0; dtype1 = 3'd0; addr1 = 32'h24;
    prev0 = 0; prev1 = 0;
    for (int i = 0; i < 10; i++) begin
      p1 = ((i % 5) == 4);
      sample();
      checks += 4;
      if (gnt1 !== p1) begin errors++; $display("[TB] FAIL starve_gnt1 cyc %0d: got %b expected %b", i, gnt1, p1); end
      if (gnt0 !== !p1) begin errors++; $display("[TB] FAIL starve_gnt0 cyc %0d: got %b expected %b", i, gnt0, !p1); end
      if (rvalid0 !== prev0) begin errors++; $display("[TB] FAIL starve_rvalid0 cyc %0d: got %b expected %b", i, rvalid0, prev0); end
      if (rvalid1 !== prev1) begin errors++; $display("[TB] FAIL starve_rvalid1 cyc %0d: got %b expected %b", i, rvalid1, prev1); end
      prev0 = !p1; prev1 = p1;
      next_cycle();
    end
    req0 = 0; req1 = 0;
    sample();
    checks++;
    if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin
      errors++; $display("[TB] FAIL starve_last_rvalid: got %b%b expected 10", rvalid1, rvalid0);
    end
    next_cycle();
  endtask

  task automatic test_byte_reads();
    do_reset();
    req1 = 1; we1 = 1; dtype1 = 3'd0; addr1 = 32'h10; wdata1 = 32'h80FF0000;
    sample();
    next_cycle();
    we1 = 0; dtype1 = 3'd2; addr1 = 32'h13;
    sample();
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("[TB] FAIL byte_gnt1: got %b expected 1", gnt1); end
    next_cycle();
    dtype1 = 3'd4;
    sample();
    checks += 3;
    if (rvalid1 !== 1'b1) begin errors++; $display("[TB] FAIL byte_rvalid1: got %b expected 1", rvalid1); end
    if (rdata1 !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL byte_signed: got %h expected ffffff80", rdata1); end
    if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL byte_err1: got %b expected 0", err1); end
    next_cycle();
    req1 = 0;
    sample();
    checks++;
    if (rdata1 !== 32'h00000080) begin errors++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", rdata1); end
    next_cycle();
  endtask

  task automatic test_illegal();
    do_reset();
    req0 = 1; we0 = 1; dtype0 = 3'd0; addr0 = 32'h12; wdata0 = 32'h55555555;
    sample();
    checks += 2;
    if (gnt0 !== 1'b1) begin errors++; $display("[TB] FAIL ill_gnt0: got %b expected 1", gnt0); end
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL ill_mem_we: got %b expected 0", mem_we); end
    next_cycle();
    dtype0 = 3'd3; addr0 = 32'h14;
    sample();
    checks += 4;
    if (rvalid0 !== 1'b1) begin errors++; $display("[TB] FAIL ill_rvalid0: got %b expected 1", rvalid0); end
    if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL ill_err0: got %b expected 1", err0); end
    if (rdata0 !== 32'd0) begin errors++; $display("[TB] FAIL ill_rdata0: got %h expected 0", rdata0); end
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL ill_hu_mem_we: got %b expected 0", mem_we); end
    next_cycle();
    we0 = 0; dtype0 = 3'd0; addr0 = 32'h10;
    sample();
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL ill_hu_err0: got %b expected 1", err0); end
    next_cycle();
    req0 = 0;
    sample();
    checks += 3;
    if (rdata0 !== 32'h80FF0000) begin errors++; $display("[TB] FAIL ill_unchanged: got %h expected 80ff0000", rdata0); end
    if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL ill_read_err0: got %b expected 0", err0); end
    if (mem[5] !== ref_mem[5]) begin errors++; $display("[TB] FAIL ill_mem14: got %h expected %h", mem[5], ref_mem[5]); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    req1 = 1; we1 = 1; dtype1 = 3'd0; addr1 = 32'h20; wdata1 = 32'h12345678;
    #2;
    checks += 2;
    if (gnt1 !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_gnt1: got %b expected 1", gnt1); end
    if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_mem_we: got %b expected 1", mem_we); end
    rst = 1;
    #1;
    checks += 4;
    if (gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL arst_gnt1: got %b expected 0", gnt1); end
    if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL arst_mem_we: got %b expected 0", mem_we); end
    if (mem_adress !== 32'd0) begin errors++; $display("[TB] FAIL arst_mem_adress: got %h expected 0", mem_adress); end
    if (wr_data !== 32'd0) begin errors++; $display("[TB] FAIL arst_wr_data: got %h expected 0", wr_data); end
    req1 = 0;
    #1 rst = 0;
    model_reset();
    sample();
    checks++;
    if (rvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL arst_rvalid1: got %b expected 0", rvalid1); end
    next_cycle();
    sample();
    checks += 2;
    if (rvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL arst_rvalid1_late: got %b expected 0", rvalid1); end
    if (mem[8] !== ref_mem[8]) begin errors++; $display("[TB] FAIL arst_no_write: got %h expected %h", mem[8], ref_mem[8]); end
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!req0 || eg0) begin
        req0 = ($urandom_range(0, 3) != 0);
        if (req0) new_req(we0, dtype0, addr0, wdata0);
      end
      if (!req1 || eg1) begin
        req1 = ($urandom_range(0, 1) != 0);
        if (req1) new_req(we1, dtype1, addr1, wdata1);
      end
      sample();
      checks += 12;
      if (gnt0 !== eg0) begin errors++; $display("[TB] FAIL rand_gnt0 cyc %0d: got %b expected %b", c, gnt0, eg0); end
      if (gnt1 !== eg1) begin errors++; $display("[TB] FAIL rand_gnt1 cyc %0d: got %b expected %b", c, gnt1, eg1); end
      if (mem_we !== e_we) begin errors++; $display("[TB] FAIL rand_mem_we cyc %0d: got %b expected %b", c, mem_we, e_we); end
      if (mem_adress !== e_addr) begin errors++; $display("[TB] FAIL rand_mem_adress cyc %0d: got %h expected %h", c, mem_adress, e_addr); end
      if (data_type !== e_type) begin errors++; $display("[TB] FAIL rand_data_type cyc %0d: got %h expected %h", c, data_type, e_type); end
      if (wr_data !== e_wd) begin errors++; $display("[TB] FAIL rand_wr_data cyc %0d: got %h expected %h", c, wr_data, e_wd); end
      if (rvalid0 !== erv0) begin errors++; $display("[TB] FAIL rand_rvalid0 cyc %0d: got %b expected %b", c, rvalid0, erv0); end
      if (rvalid1 !== erv1) begin errors++; $display("[TB] FAIL rand_rvalid1 cyc %0d: got %b expected %b", c, rvalid1, erv1); end
      if (rdata0 !== erd0) begin errors++; $display("[TB] FAIL rand_rdata0 cyc %0d: got %h expected %h", c, rdata0, erd0); end
      if (rdata1 !== erd1) begin errors++; $display("[TB] FAIL rand_rdata1 cyc %0d: got %h expected %h", c, rdata1, erd1); end
      if (err0 !== eerr0) begin errors++; $display("[TB] FAIL rand_err0 cyc %0d: got %b expected %b", c, err0, eerr0); end
      if (err1 !== eerr1) begin errors++; $display("[TB] FAIL rand_err1 cyc %0d: got %b expected %b", c, err1, eerr1); end
      next_cycle();
    end
    req0 = 0; req1 = 0;
    sample();
    next_cycle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req0 = 1; we0 = 0; dtype0 = 3'd0; addr0 = 32'h00;
    req1 = 1; we1 = 0; dtype1 = 3'd0; addr1 = 32'h04;
    for (int i = 0; i < 3; i++) begin sample(); next_cycle(); end
    req0 = 0;
    for (int i = 0; i < 2; i++) begin sample(); next_cycle(); end
    req1 = 0;
    sample();
    checks += 4;
    if (stat_conflict !== 16'd3) begin errors++; $display("[TB] FAIL stat_conflict: got %0d expected 3", stat_conflict); end
    if (stat_gnt0 !== 16'd3) begin errors++; $display("[TB] FAIL stat_gnt0: got %0d expected 3", stat_gnt0); end
    if (stat_gnt1 !== 16'd2) begin errors++; $display("[TB] FAIL stat_gnt1: got %0d expected 2", stat_gnt1); end
    if (int'(stat_gnt0) != m_sg0 || int'(stat_gnt1) != m_sg1 || int'(stat_conflict) != m_sc) begin
      errors++;
      $display("[TB] FAIL stat_model: got %0d %0d %0d expected %0d %0d %0d",
               stat_gnt0, stat_gnt1, stat_conflict, m_sg0, m_sg1, m_sc);
    end
    next_cycle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_write_read();
    test_starvation();
    test_byte_reads();
    test_illegal();
    test_async_reset();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
